// File: rtl/sreg_feeder.sv
// Parallel-to-serial feeder: buffers words in a small FIFO and streams them MSB-first
// into a downstream shift register with no gap between consecutive words.
module sreg_feeder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pinp,
  input  logic             pvalid,
  output logic             pready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             push;
  logic             load;
  logic             fifo_empty;
  logic [WIDTH-1:0] head;

  // pready comes from the registered count only; a pop on the same edge cannot bypass it
  assign pready     = (count_q < CW'(DEPTH));
  assign push       = pvalid && pready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sout_d  = sout_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          sout_d = 1'b0;
          vld_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          shreg_d = shreg_q << 1;
          sout_d  = shreg_q[WIDTH-2];
          cnt_d   = cnt_q - NW'(1);
          done_d  = (cnt_q == NW'(1));
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
          sout_d  = 1'b0;
          vld_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Loading from SHIFT while the LSB is out keeps the stream bubble-free
    if (load) begin
      shreg_d = head;
      sout_d  = head[WIDTH-1];
      vld_d   = 1'b1;
      cnt_d   = NW'(WIDTH - 1);
      state_d = SHIFT;
    end
  end

  always_comb begin
    rd_d    = load ? rd_q + PW'(1) : rd_q;
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    count_d = count_q + CW'(push) - CW'(load);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (push) mem_q[wr_q] <= pinp;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = vld_q;
  assign word_done  = done_q;
  assign busy       = (state_q == SHIFT) || !fifo_empty;

endmodule

// File: tb/tb_sreg_feeder.sv
// Bench for sreg_feeder: table vectors, hand sequences and a random run against a word-queue model.
module tb_sreg_feeder;
  localparam int W = 4;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] pinp = '0;
  logic         pvalid = 1'b0;
  logic         pready, sout, sout_valid, word_done, busy;

  sreg_feeder #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pinp(pinp), .pvalid(pvalid), .pready(pready),
    .sout(sout), .sout_valid(sout_valid), .word_done(word_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of buffered words, current word, and bits of it still to show
  logic [W-1:0] mq[$];
  logic [W-1:0] cur = '0;
  int           bl = 0;
  int           n_acc = 0;
  int           n_done = 0;
  logic [W-1:0] sipo = '0;

  typedef struct {
    logic         pv;
    logic [W-1:0] d;
    logic [3:0]   exp;  // {sout, sout_valid, word_done, pready}
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] model_exp();
    logic s;
    s = (bl > 0) ? cur[bl-1] : 1'b0;
    return {s, bl > 0, bl == 1, mq.size() < DEPTH, (bl > 0) || (mq.size() > 0)};
  endfunction

  task automatic model_edge(input logic pv, input logic [W-1:0] d);
    bit acc;
    acc = pv && (mq.size() < DEPTH);
    if (bl <= 1 && mq.size() > 0) begin
      cur = mq.pop_front();
      bl  = W;
    end else if (bl > 0) begin
      bl--;
    end
    if (acc) begin
      mq.push_back(d);
      n_acc++;
    end
  endtask

  task automatic model_clear();
    mq.delete();
    cur = '0;
    bl = 0;
    n_acc = 0;
    n_done = 0;
  endtask

  // Drives inputs, crosses one rising edge, then compares #1 later
  task automatic step(input logic pv, input logic [W-1:0] d);
    logic         ps, pd;
    logic [W-1:0] fin;
    pvalid = pv;
    pinp   = d;
    ps     = sout;
    pd     = word_done;
    fin    = cur;
    @(posedge clk);
    sipo = {sipo[W-2:0], ps};
    if (pd) chk("sipo_word", 32'(sipo), 32'(fin));
    model_edge(pv, d);
    #1;
    if (word_done) n_done++;
    chk("cycle", 32'({sout, sout_valid, word_done, pready, busy}), 32'(model_exp()));
  endtask

  task automatic hard_reset();
    reset  = 1'b0;
    pvalid = 1'b0;
    #1;
    model_clear();
    chk("reset_outputs", 32'({sout, sout_valid, word_done, pready, busy}), 32'b00010);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 4'b1011, 4'b0001};
    tbl[1]  = '{1'b0, 4'b0000, 4'b1101};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0101};
    tbl[3]  = '{1'b0, 4'b0000, 4'b1101};
    tbl[4]  = '{1'b0, 4'b0000, 4'b1111};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0001};
    tbl[6]  = '{1'b1, 4'b1000, 4'b0001};
    tbl[7]  = '{1'b1, 4'b0110, 4'b1101};
    tbl[8]  = '{1'b1, 4'b1111, 4'b0100};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0100};
    tbl[10] = '{1'b0, 4'b0000, 4'b0110};
    tbl[11] = '{1'b0, 4'b0000, 4'b0101};
    tbl[12] = '{1'b0, 4'b0000, 4'b1101};
    tbl[13] = '{1'b0, 4'b0000, 4'b1101};
    tbl[14] = '{1'b0, 4'b0000, 4'b0111};
    tbl[15] = '{1'b0, 4'b0000, 4'b1101};
    tbl[16] = '{1'b0, 4'b0000, 4'b1101};
    tbl[17] = '{1'b0, 4'b0000, 4'b1101};
    tbl[18] = '{1'b0, 4'b0000, 4'b1111};
    tbl[19] = '{1'b0, 4'b0000, 4'b0001};

    hard_reset();

    // Single word then back-to-back stream, hand-derived expectations
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].pv, tbl[i].d);
      chk($sformatf("tbl_%0d", i), 32'({sout, sout_valid, word_done, pready}), 32'(tbl[i].exp));
    end

    // Downstream SIPO holds the word on the cycle after word_done
    step(1'b1, 4'b1001);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000);
    chk("sipo_1001", 32'(sipo), 32'b1001);

    // Idle gap between two words
    n_done = 0;
    step(1'b1, 4'b1100);
    for (int i = 0; i < 8; i++) step(1'b0, 4'b0000);
    chk("gap_vld", 32'(sout_valid), 32'd0);
    step(1'b1, 4'b0011);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000);
    chk("gap_done_count", 32'(n_done), 32'd2);

    // Reset after two bits of 1010 with another word queued
    step(1'b1, 4'b1010);
    step(1'b1, 4'b0111);
    step(1'b0, 4'b0000);
    hard_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);
    chk("post_reset_idle", 32'({sout_valid, busy}), 32'd0);
    step(1'b1, 4'b0001);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000);
    chk("post_reset_word", 32'(n_done), 32'd1);
    chk("post_reset_sipo", 32'(sipo), 32'b0001);

    // Random traffic with bursts that hold pvalid against a full FIFO
    for (int i = 0; i < 800; i++) begin
      logic pv;
      pv = ((i % 100) < 50) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      step(pv, W'($urandom_range(0, 15)));
    end
    begin
      int k = 0;
      while ((bl > 0 || mq.size() > 0) && k < 30) begin
        step(1'b0, 4'b0000);
        k++;
      end
      step(1'b0, 4'b0000);
    end
    chk("drain_busy", 32'(busy), 32'd0);
    chk("word_count", 32'(n_done), 32'(n_acc));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
